mfe_image_server: RTL and testbench

- Memory-side responder for the median filter engine.
- Accepts a host pixel stream into a grayscale frame buffer, then raises `ready`.
- While the engine runs, answers its pixel reads (`iaddr`→`idata`), captures its result writes (`wen`/`addr`/`data_wr`), and serves `data_rd`.
- When the engine drops `busy`, streams the result frame back to the host.

---
 rtl/mfe_image_server_if.sv | 35 +++
 rtl/mfe_image_server.sv | 145 ++++++++++++++
 tb/tb_mfe_image_server.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfe_image_server_if.sv
// Signal bundle between the image server, the host pixel streams and the
// median filter engine. The server uses the slave view, the host/engine the master view.
interface mfe_image_server_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_wr;
    logic [DW-1:0] data_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          err;
    logic          restart;

    modport slave (
        input  in_valid, in_data, busy, iaddr, wen, addr, data_wr, out_ready, restart,
        output in_ready, ready, idata, data_rd, out_valid, out_data, out_last, done, err
    );

    modport master (
        output in_valid, in_data, busy, iaddr, wen, addr, data_wr, out_ready, restart,
        input  in_ready, ready, idata, data_rd, out_valid, out_data, out_last, done, err
    );
endinterface

// File: rtl/mfe_image_server.sv
// Memory-side responder for the median filter engine: loads a grayscale frame,
// serves engine reads and result writes, then streams the result frame to the host.
module mfe_image_server #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    mfe_image_server_if.slave bus
);
    localparam int            N     = IMG_W * IMG_H;
    localparam int            IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW:0]   N_EXT = (AW+1)'(N);
    localparam logic [AW-1:0] LAST  = AW'(N - 1);
    localparam logic [AW-1:0] ONE   = AW'(1);

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [DW-1:0] gram [N];
    logic [DW-1:0] rram [N];
    logic [AW-1:0] load_ptr_r, rd_ptr_r;
    logic          fetch_end_r, busy_q_r;
    logic          eng_s, load_fire_s, out_fire_s, fetch_s, restart_s;
    logic          iaddr_ok_s, addr_ok_s;

    // Next-state decode and per-cycle qualifiers.
    always_comb begin
        state_s     = state_r;
        eng_s       = (state_r == ARM) || (state_r == RUN);
        load_fire_s = (state_r == LOAD) && bus.in_valid;
        out_fire_s  = (state_r == DRAIN) && bus.out_valid && bus.out_ready;
        fetch_s     = (state_r == DRAIN) && !fetch_end_r && (!bus.out_valid || bus.out_ready);
        restart_s   = (state_r == DONE) && bus.restart;
        iaddr_ok_s  = ({1'b0, bus.iaddr} < N_EXT);
        addr_ok_s   = ({1'b0, bus.addr} < N_EXT);
        case (state_r)
            LOAD: begin
                if (load_fire_s && (load_ptr_r == LAST)) state_s = ARM;
                else                                     state_s = LOAD;
            end
            ARM: begin
                // busy_q_r is forced low outside ARM/RUN, so busy already high on entry counts as a rise
                if (bus.busy && !busy_q_r) state_s = RUN;
                else                       state_s = ARM;
            end
            RUN: begin
                if (!bus.busy && busy_q_r) state_s = DRAIN;
                else                       state_s = RUN;
            end
            DRAIN: begin
                if (out_fire_s && bus.out_last) state_s = DONE;
                else                            state_s = DRAIN;
            end
            DONE: begin
                if (bus.restart) state_s = LOAD;
                else             state_s = DONE;
            end
            default: state_s = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= LOAD;
        else        state_r <= state_s;
    end

    // Pointers, busy edge history, sticky error and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ptr_r   <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            fetch_end_r  <= 1'b0;
            busy_q_r     <= 1'b0;
            bus.err      <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.ready    <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.in_ready <= (state_s == LOAD);
            bus.ready    <= (state_s == ARM) || (state_s == RUN);
            bus.done     <= (state_s == DONE);
            busy_q_r     <= eng_s && bus.busy;
            if (restart_s) begin
                load_ptr_r  <= {AW{1'b0}};
                rd_ptr_r    <= {AW{1'b0}};
                fetch_end_r <= 1'b0;
                bus.err     <= 1'b0;
            end else begin
                if (load_fire_s && (load_ptr_r != LAST)) load_ptr_r <= load_ptr_r + ONE;
                if (fetch_s) begin
                    if (rd_ptr_r == LAST) fetch_end_r <= 1'b1;
                    else                  rd_ptr_r    <= rd_ptr_r + ONE;
                end
                if (eng_s && bus.wen && !addr_ok_s) bus.err <= 1'b1;
            end
        end
    end

    // Frame storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (load_fire_s)                   gram[load_ptr_r[IW-1:0]] <= bus.in_data;
        if (eng_s && bus.wen && addr_ok_s) rram[bus.addr[IW-1:0]]   <= bus.data_wr;
    end

    // Engine-facing read ports; rram read sees the pre-write value on a same-cycle write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.idata   <= {DW{1'b0}};
            bus.data_rd <= {DW{1'b0}};
        end else begin
            if (eng_s && iaddr_ok_s) bus.idata <= gram[bus.iaddr[IW-1:0]];
            else                     bus.idata <= {DW{1'b0}};
            if (addr_ok_s) bus.data_rd <= rram[bus.addr[IW-1:0]];
            else           bus.data_rd <= {DW{1'b0}};
        end
    end

    // Result stream output register: refills whenever empty or being consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= {DW{1'b0}};
            bus.out_last  <= 1'b0;
        end else if (fetch_s) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= rram[rd_ptr_r[IW-1:0]];
            bus.out_last  <= (rd_ptr_r == LAST);
        end else if (out_fire_s) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            bus.out_valid <= bus.out_valid;
        end
    end
endmodule

// File: tb/tb_mfe_image_server.sv
// Scoreboard bench for mfe_image_server: stimulus queues expectations, a
// negedge monitor pops and compares them against what the DUT presents.
module tb_mfe_image_server;
    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int N     = IMG_W * IMG_H;

    localparam int S_READY = 0, S_IN_READY = 1, S_DONE = 2, S_ERR = 3, S_OUT_VALID = 4;
    localparam int S_IDATA = 5, S_DATA_RD = 6, S_OUT_DATA = 7, S_OUT_LAST = 8;
    localparam int S_BEATS = 9, S_QLEFT = 10;

    typedef struct { int id; logic [31:0] exp; } stat_t;
    typedef struct { logic [7:0] d; logic l; } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mfe_image_server_if #(.AW(AW), .DW(DW)) bus();

    mfe_image_server #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         beats = 0;
    stat_t      q_stat[$];
    beat_t      q_out[$];
    logic [7:0] q_idata[$];
    logic [7:0] q_drd[$];
    logic       i_req  = 1'b0;
    logic       d_req  = 1'b0;
    logic       i_pend = 1'b0;
    logic       d_pend = 1'b0;
    logic [3:0] pat    = 4'b1001;

    function automatic logic [31:0] pick(input int id);
        case (id)
            S_READY:     return {31'd0, bus.ready};
            S_IN_READY:  return {31'd0, bus.in_ready};
            S_DONE:      return {31'd0, bus.done};
            S_ERR:       return {31'd0, bus.err};
            S_OUT_VALID: return {31'd0, bus.out_valid};
            S_IDATA:     return {24'd0, bus.idata};
            S_DATA_RD:   return {24'd0, bus.data_rd};
            S_OUT_DATA:  return {24'd0, bus.out_data};
            S_OUT_LAST:  return {31'd0, bus.out_last};
            S_BEATS:     return 32'(beats);
            S_QLEFT:     return 32'(q_out.size());
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic string sname(input int id);
        case (id)
            S_READY:     return "ready";
            S_IN_READY:  return "in_ready";
            S_DONE:      return "done";
            S_ERR:       return "err";
            S_OUT_VALID: return "out_valid";
            S_IDATA:     return "idata";
            S_DATA_RD:   return "data_rd";
            S_OUT_DATA:  return "out_data";
            S_OUT_LAST:  return "out_last";
            S_BEATS:     return "beat_count";
            S_QLEFT:     return "beats_missing";
            default:     return "unknown";
        endcase
    endfunction

    // Monitor: status expectations, 1-cycle read responses and the result stream.
    always @(negedge clk) begin
        stat_t      s;
        logic [7:0] e;
        beat_t      b;
        while (q_stat.size() > 0) begin
            s = q_stat.pop_front();
            total++;
            if (pick(s.id) !== s.exp) begin
                bad++;
                $display("FAIL %s got=%0h exp=%0h t=%0t", sname(s.id), pick(s.id), s.exp, $time);
            end
        end
        if (i_pend) begin
            total++;
            if (q_idata.size() == 0) begin
                bad++;
                $display("FAIL idata_read no expectation got=%0h", bus.idata);
            end else begin
                e = q_idata.pop_front();
                if (bus.idata !== e) begin
                    bad++;
                    $display("FAIL idata_read got=%0h exp=%0h t=%0t", bus.idata, e, $time);
                end
            end
        end
        if (d_pend) begin
            total++;
            if (q_drd.size() == 0) begin
                bad++;
                $display("FAIL data_rd_read no expectation got=%0h", bus.data_rd);
            end else begin
                e = q_drd.pop_front();
                if (bus.data_rd !== e) begin
                    bad++;
                    $display("FAIL data_rd_read got=%0h exp=%0h t=%0t", bus.data_rd, e, $time);
                end
            end
        end
        i_pend = i_req;
        d_pend = d_req;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            total++;
            if (q_out.size() == 0) begin
                bad++;
                $display("FAIL out_beat extra beat=%0d got=%0h", beats, bus.out_data);
            end else begin
                b = q_out.pop_front();
                if (bus.out_data !== b.d || bus.out_last !== b.l) begin
                    bad++;
                    $display("FAIL out_beat idx=%0d got=%0h/%0b exp=%0h/%0b",
                             beats, bus.out_data, bus.out_last, b.d, b.l);
                end
            end
            beats++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int id, input logic [31:0] v);
        q_stat.push_back('{id, v});
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.busy      = 1'b0;
        bus.iaddr     = 15'd0;
        bus.wen       = 1'b0;
        bus.addr      = 15'd0;
        bus.data_wr   = 8'd0;
        bus.out_ready = 1'b0;
        bus.restart   = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        expect_sig(S_IN_READY, 32'd1);
        expect_sig(S_READY, 32'd0);
        expect_sig(S_IDATA, 32'd0);
        expect_sig(S_DATA_RD, 32'd0);
        expect_sig(S_OUT_VALID, 32'd0);
        expect_sig(S_OUT_DATA, 32'd0);
        expect_sig(S_OUT_LAST, 32'd0);
        expect_sig(S_DONE, 32'd0);
        expect_sig(S_ERR, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Frame 1: ramp load
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k);
            if (k == 100) begin
                expect_sig(S_READY, 32'd0);
                expect_sig(S_IN_READY, 32'd1);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        expect_sig(S_READY, 32'd1);
        expect_sig(S_IN_READY, 32'd0);

        // Engine reads in ARM, including one out of range
        i_req = 1'b1;
        bus.iaddr = 15'd129;   q_idata.push_back(8'd129); tick();
        bus.iaddr = 15'd16383; q_idata.push_back(8'd255); tick();
        bus.iaddr = 15'd16384; q_idata.push_back(8'd0);   tick();
        i_req = 1'b0;
        bus.iaddr = 15'd0;
        bus.busy = 1'b1;
        tick();
        expect_sig(S_READY, 32'd1);

        // Result writes and read-before-write on addr 5
        bus.wen = 1'b1; bus.addr = 15'd5; bus.data_wr = 8'h3C; tick();
        bus.wen = 1'b0; d_req = 1'b1; q_drd.push_back(8'h3C); tick();
        bus.wen = 1'b1; bus.data_wr = 8'h77; q_drd.push_back(8'h3C); tick();
        bus.wen = 1'b0; q_drd.push_back(8'h77); tick();
        d_req = 1'b0;

        // Full result frame
        for (int i = 0; i < N; i++) begin
            bus.wen     = 1'b1;
            bus.addr    = 15'(i);
            bus.data_wr = 8'(255 - (i % 256));
            tick();
        end
        bus.wen = 1'b0; bus.addr = 15'd0; d_req = 1'b1; q_drd.push_back(8'd255);
        expect_sig(S_ERR, 32'd0);
        tick();
        bus.wen = 1'b1; bus.addr = 15'd16384; bus.data_wr = 8'hAA; q_drd.push_back(8'd0);
        tick();
        bus.wen = 1'b0; d_req = 1'b0;
        expect_sig(S_ERR, 32'd1);
        tick();

        // Drain with backpressure
        for (int i = 0; i < N; i++) q_out.push_back('{8'(255 - (i % 256)), (i == N - 1)});
        bus.busy = 1'b0;
        tick();
        expect_sig(S_READY, 32'd0);
        tick();
        expect_sig(S_OUT_VALID, 32'd1);
        for (int c = 0; c < 3 * N && !bus.done; c++) begin
            bus.out_ready = (c < 40) ? pat[c % 4] : 1'b1;
            tick();
        end
        expect_sig(S_DONE, 32'd1);
        expect_sig(S_OUT_VALID, 32'd0);
        expect_sig(S_ERR, 32'd1);
        expect_sig(S_BEATS, 32'(N));
        expect_sig(S_QLEFT, 32'd0);
        tick();

        // Restart clears done/err
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        expect_sig(S_ERR, 32'd0);
        expect_sig(S_IN_READY, 32'd1);
        expect_sig(S_DONE, 32'd0);
        expect_sig(S_READY, 32'd0);

        // Frame 2 with busy already high on ARM entry
        bus.busy = 1'b1;
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'((k * 3) & 255);
            tick();
        end
        bus.in_valid = 1'b0;
        i_req = 1'b1;
        bus.iaddr = 15'd7; q_idata.push_back(8'd21);
        tick();
        i_req = 1'b0;
        expect_sig(S_READY, 32'd1);
        tick();

        // Asynchronous reset mid-RUN
        reset = 1'b0;
        expect_sig(S_READY, 32'd0);
        expect_sig(S_IDATA, 32'd0);
        expect_sig(S_OUT_VALID, 32'd0);
        expect_sig(S_IN_READY, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        bus.busy = 1'b0;
        tick();
        expect_sig(S_IN_READY, 32'd1);
        expect_sig(S_READY, 32'd0);
        expect_sig(S_DONE, 32'd0);
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
